// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and helpers for the execute-stage control-flow logic.
package riscv_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    PC_SRC_SEQ  = 2'b00,
    PC_SRC_BR   = 2'b01,
    PC_SRC_JALR = 2'b10
  } pc_src_e;

  // Comparator outcome for a conditional branch; reserved funct3 codes never take.
  function automatic logic branch_cond(input logic [2:0] funct3, input logic eq, input logic lt);
    logic res;
    case (funct3)
      F3_BEQ:          res = eq;
      F3_BNE:          res = ~eq;
      F3_BLT, F3_BLTU: res = lt;
      F3_BGE, F3_BGEU: res = ~lt;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_reserved_br_f3(input logic [2:0] funct3);
    return (funct3 == 3'b010) || (funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/flush_shreg.sv
// DEPTH-bit squash shift register with synchronous clear; bit 0 holds the newest entry.
module flush_shreg #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [DEPTH-1:0] vec,
  output logic             any
);

  logic [DEPTH-1:0] vec_r;

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage window: the register simply follows the input.
      always_ff @(posedge clk) begin
        if (rst) vec_r <= 1'b0;
        else     vec_r <= din;
      end
    end else begin : g_multi
      // Shift the new entry in at bit 0.
      always_ff @(posedge clk) begin
        if (rst) vec_r <= {DEPTH{1'b0}};
        else     vec_r <= {vec_r[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign vec = vec_r;
  assign any = |vec_r;

endmodule

// File: rtl/br_flush_ctrl.sv
// EX-stage branch/jump resolver, PC redirect and squash controller.
// Optional performance counters are compiled in with `define BR_FLUSH_PERF_EN.
module br_flush_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3,
  parameter int CTRL_W      = 6,
  parameter int MEM_W       = 2,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            inst,
  input  logic                   br_eq,
  input  logic                   br_lt,
  input  logic                   hold_in,
  input  logic [MEM_W-1:0]       mem_we_in,
  input  logic                   reg_wen_in,
  input  logic [CTRL_W-1:0]      ctrl_in,
  output logic [MEM_W-1:0]       mem_we_ex,
  output logic                   reg_wen_q,
  output logic [CTRL_W-1:0]      ctrl_q,
  output logic                   pc_sel,
  output logic [1:0]             pc_src,
  output logic [FLUSH_DEPTH-1:0] flush_vec,
  output logic                   flush_active,
  output logic                   illegal_br_q
`ifdef BR_FLUSH_PERF_EN
  ,
  output logic [CNT_W-1:0]       br_cnt,
  output logic [CNT_W-1:0]       br_taken_cnt,
  output logic [CNT_W-1:0]       flush_cyc_cnt
`endif
);

  logic [4:0]             opcode_s;
  logic [2:0]             funct3_s;
  logic                   kill_s;
  logic                   take_s;
  logic                   illegal_s;
  logic                   unused_inst_s;
  logic [MEM_W-1:0]       mem_we_s;
  logic [FLUSH_DEPTH-1:0] flush_vec_s;
  logic                   flush_active_s;
  pc_src_e                pc_src_r;
  logic                   reg_wen_r;
  logic [CTRL_W-1:0]      ctrl_r;
  logic                   illegal_r;

  assign opcode_s      = inst[6:2];
  assign funct3_s      = inst[14:12];
  assign unused_inst_s = ^{inst[31:15], inst[11:7], inst[1:0]};
  assign kill_s        = hold_in | flush_active_s;
  assign illegal_s     = (opcode_s == OPC_BRANCH) & is_reserved_br_f3(funct3_s) & ~kill_s;

  // Resolve whether the instruction in EX redirects the PC.
  always_comb begin
    take_s = 1'b0;
    if (kill_s) begin
      take_s = 1'b0;
    end else begin
      case (opcode_s)
        OPC_BRANCH:        take_s = branch_cond(funct3_s, br_eq, br_lt);
        OPC_JAL, OPC_JALR: take_s = 1'b1;
        default:           take_s = 1'b0;
      endcase
    end
  end

  // Store enable must be blocked in the same cycle the slot is killed.
  always_comb begin
    mem_we_s = {MEM_W{1'b0}};
    if (kill_s) mem_we_s = {MEM_W{1'b0}};
    else        mem_we_s = mem_we_in;
  end

  flush_shreg #(.DEPTH(FLUSH_DEPTH)) u_flush_shreg (
    .clk (clk),
    .rst (rst),
    .din (take_s),
    .vec (flush_vec_s),
    .any (flush_active_s)
  );

  // Redirect source, gated writeback controls and the sticky illegal-branch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_src_r  <= PC_SRC_SEQ;
      reg_wen_r <= 1'b0;
      ctrl_r    <= {CTRL_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      if (take_s) pc_src_r <= (opcode_s == OPC_JALR) ? PC_SRC_JALR : PC_SRC_BR;
      else        pc_src_r <= PC_SRC_SEQ;
      reg_wen_r <= kill_s ? 1'b0 : reg_wen_in;
      // A held bubble keeps its bundle; only the squash window clears it.
      ctrl_r    <= flush_active_s ? {CTRL_W{1'b0}} : ctrl_in;
      illegal_r <= illegal_r | illegal_s;
    end
  end

  assign mem_we_ex    = mem_we_s;
  assign reg_wen_q    = reg_wen_r;
  assign ctrl_q       = ctrl_r;
  assign pc_sel       = flush_vec_s[0];
  assign pc_src       = pc_src_r;
  assign flush_vec    = flush_vec_s;
  assign flush_active = flush_active_s;
  assign illegal_br_q = illegal_r;

`ifdef BR_FLUSH_PERF_EN
  logic             ctl_ev_s;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] br_taken_cnt_r;
  logic [CNT_W-1:0] flush_cyc_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
    logic [CNT_W-1:0] res;
    if (en && (val != {CNT_W{1'b1}})) res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    else                              res = val;
    return res;
  endfunction

  assign ctl_ev_s = ~kill_s & ((opcode_s == OPC_BRANCH) | (opcode_s == OPC_JAL) | (opcode_s == OPC_JALR));

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_r        <= {CNT_W{1'b0}};
      br_taken_cnt_r  <= {CNT_W{1'b0}};
      flush_cyc_cnt_r <= {CNT_W{1'b0}};
    end else begin
      br_cnt_r        <= sat_inc(br_cnt_r, ctl_ev_s);
      br_taken_cnt_r  <= sat_inc(br_taken_cnt_r, take_s);
      flush_cyc_cnt_r <= sat_inc(flush_cyc_cnt_r, flush_active_s);
    end
  end

  assign br_cnt        = br_cnt_r;
  assign br_taken_cnt  = br_taken_cnt_r;
  assign flush_cyc_cnt = flush_cyc_cnt_r;
`endif

endmodule

// File: tb/tb_br_flush_ctrl.sv
// Self-checking bench for br_flush_ctrl: directed vector table, hand sequences, random vs. model.
module tb_br_flush_ctrl;
  import riscv_pkg::*;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        br_eq, br_lt, hold_in, reg_wen_in;
  logic [1:0]  mem_we_in;
  logic [5:0]  ctrl_in;
  logic [1:0]  mem_we_ex;
  logic        reg_wen_q;
  logic [5:0]  ctrl_q;
  logic        pc_sel;
  logic [1:0]  pc_src;
  logic [D-1:0] flush_vec;
  logic        flush_active;
  logic        illegal_br_q;
`ifdef BR_FLUSH_PERF_EN
  logic [31:0] br_cnt, br_taken_cnt, flush_cyc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  br_flush_ctrl #(.FLUSH_DEPTH(D), .CTRL_W(6), .MEM_W(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst(inst), .br_eq(br_eq), .br_lt(br_lt), .hold_in(hold_in),
    .mem_we_in(mem_we_in), .reg_wen_in(reg_wen_in), .ctrl_in(ctrl_in),
    .mem_we_ex(mem_we_ex), .reg_wen_q(reg_wen_q), .ctrl_q(ctrl_q), .pc_sel(pc_sel),
    .pc_src(pc_src), .flush_vec(flush_vec), .flush_active(flush_active),
    .illegal_br_q(illegal_br_q)
`ifdef BR_FLUSH_PERF_EN
    , .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt), .flush_cyc_cnt(flush_cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic eq, lt, hold;
    logic [1:0] mem;
    logic reg_wen;
    logic [5:0] ctrl;
    logic e_pc_sel;
    logic [1:0] e_pc_src;
    logic [2:0] e_fv;
    logic [1:0] e_mem;
    logic e_reg;
    logic [5:0] e_ctrl;
    logic e_ill;
  } vec_t;

  vec_t tbl[14];

  // Reference state: age = cycles since the last redirect (0 = none in flight).
  int  m_age;
  bit  m_jalr, m_reg, m_ill;
  logic [5:0] m_ctrl;
  longint m_br, m_taken, m_fcyc;

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc, 2'b11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic [31:0] i, input logic e, input logic l,
                        input logic h, input logic [1:0] m, input logic w, input logic [5:0] c);
    rst = r; inst = i; br_eq = e; br_lt = l; hold_in = h; mem_we_in = m; reg_wen_in = w; ctrl_in = c;
  endtask

  // One clock: check outputs at negedge against the model (and optional table row), then advance.
  task automatic do_cycle(input bit check_en, input bit use_tbl, input vec_t v);
    bit fa, kill, take, cond, is_br, is_jmp;
    logic [D-1:0] efv;
    logic [1:0] esrc;
    @(negedge clk);
    fa    = (m_age >= 1) && (m_age <= D);
    efv   = fa ? (D'(1) << (m_age - 1)) : '0;
    esrc  = (m_age == 1) ? (m_jalr ? 2'd2 : 2'd1) : 2'd0;
    kill  = hold_in || fa;
    is_br = (inst[6:2] == 5'b11000);
    is_jmp = (inst[6:2] == 5'b11011) || (inst[6:2] == 5'b11001);
    case (inst[14:12])
      3'd0: cond = br_eq;
      3'd1: cond = !br_eq;
      3'd4, 3'd6: cond = br_lt;
      3'd5, 3'd7: cond = !br_lt;
      default: cond = 1'b0;
    endcase
    take = !kill && (is_jmp || (is_br && cond));
    if (check_en) begin
      chk("flush_vec", 32'(flush_vec), 32'(efv));
      chk("flush_active", 32'(flush_active), 32'(fa));
      chk("pc_sel", 32'(pc_sel), 32'(m_age == 1));
      chk("pc_src", 32'(pc_src), 32'(esrc));
      chk("mem_we_ex", 32'(mem_we_ex), kill ? 32'd0 : 32'(mem_we_in));
      chk("reg_wen_q", 32'(reg_wen_q), 32'(m_reg));
      chk("ctrl_q", 32'(ctrl_q), 32'(m_ctrl));
      chk("illegal_br_q", 32'(illegal_br_q), 32'(m_ill));
`ifdef BR_FLUSH_PERF_EN
      chk("br_cnt", br_cnt, 32'(m_br));
      chk("br_taken_cnt", br_taken_cnt, 32'(m_taken));
      chk("flush_cyc_cnt", flush_cyc_cnt, 32'(m_fcyc));
`endif
    end
    if (use_tbl) begin
      chk("tbl_pc_sel", 32'(pc_sel), 32'(v.e_pc_sel));
      chk("tbl_pc_src", 32'(pc_src), 32'(v.e_pc_src));
      chk("tbl_flush_vec", 32'(flush_vec), 32'(v.e_fv));
      chk("tbl_mem_we_ex", 32'(mem_we_ex), 32'(v.e_mem));
      chk("tbl_reg_wen_q", 32'(reg_wen_q), 32'(v.e_reg));
      chk("tbl_ctrl_q", 32'(ctrl_q), 32'(v.e_ctrl));
      chk("tbl_illegal", 32'(illegal_br_q), 32'(v.e_ill));
    end
    if (rst) begin
      m_age = 0; m_jalr = 0; m_reg = 0; m_ctrl = '0; m_ill = 0;
      m_br = 0; m_taken = 0; m_fcyc = 0;
    end else begin
      if (take)                       m_age = 1;
      else if (m_age > 0 && m_age <= D) m_age = m_age + 1;
      else                            m_age = 0;
      m_jalr = take && (inst[6:2] == 5'b11001);
      m_reg  = kill ? 1'b0 : reg_wen_in;
      m_ctrl = fa ? 6'd0 : ctrl_in;
      m_ill  = m_ill || (is_br && (inst[14:12] inside {3'd2, 3'd3}) && !kill);
      if (!kill && (is_br || is_jmp)) m_br++;
      if (take) m_taken++;
      if (fa) m_fcyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit check_en);
    vec_t dummy;
    dummy = '{32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 6'd0, 1'b0};
    do_cycle(check_en, 1'b0, dummy);
  endtask

  initial begin
    logic [31:0] nop, beq, bne, blt, bge, jal, jalr, bill;
    logic [31:0] pool[13];
    nop  = mk(OPC_OP_IMM, 3'd0);
    beq  = mk(OPC_BRANCH, F3_BEQ);
    bne  = mk(OPC_BRANCH, F3_BNE);
    blt  = mk(OPC_BRANCH, F3_BLT);
    bge  = mk(OPC_BRANCH, F3_BGE);
    jal  = mk(OPC_JAL, 3'd0);
    jalr = mk(OPC_JALR, 3'd0);
    bill = mk(OPC_BRANCH, 3'b010);

    //          inst  eq    lt    hold  mem    wen   ctrl   psel  src    fv      mem    reg   ctrl   ill
    tbl[0]  = '{beq,  1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 6'h15, 1'b0, 2'd0, 3'b000, 2'd1, 1'b0, 6'h00, 1'b0};
    tbl[1]  = '{nop,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 6'h2A, 1'b1, 2'd1, 3'b001, 2'd0, 1'b1, 6'h15, 1'b0};
    tbl[2]  = '{nop,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 6'h2A, 1'b0, 2'd0, 3'b010, 2'd0, 1'b0, 6'h00, 1'b0};
    tbl[3]  = '{nop,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 6'h2A, 1'b0, 2'd0, 3'b100, 2'd0, 1'b0, 6'h00, 1'b0};
    tbl[4]  = '{nop,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 6'h2A, 1'b0, 2'd0, 3'b000, 2'd1, 1'b0, 6'h00, 1'b0};
    tbl[5]  = '{jalr, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'h01, 1'b0, 2'd0, 3'b000, 2'd0, 1'b1, 6'h2A, 1'b0};
    tbl[6]  = '{bne,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 6'h03, 1'b1, 2'd2, 3'b001, 2'd0, 1'b1, 6'h01, 1'b0};
    tbl[7]  = '{bne,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 6'h03, 1'b0, 2'd0, 3'b010, 2'd0, 1'b0, 6'h00, 1'b0};
    tbl[8]  = '{nop,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 2'd0, 3'b100, 2'd0, 1'b0, 6'h00, 1'b0};
    tbl[9]  = '{blt,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 6'h11, 1'b0, 2'd0, 3'b000, 2'd1, 1'b0, 6'h00, 1'b0};
    tbl[10] = '{bge,  1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 6'h22, 1'b0, 2'd0, 3'b000, 2'd0, 1'b1, 6'h11, 1'b0};
    tbl[11] = '{bill, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0, 6'h22, 1'b0};
    tbl[12] = '{nop,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0, 6'h00, 1'b1};
    tbl[13] = '{nop,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00, 1'b0, 2'd0, 3'b000, 2'd0, 1'b0, 6'h00, 1'b1};

    m_age = 0; m_jalr = 0; m_reg = 0; m_ctrl = '0; m_ill = 0; m_br = 0; m_taken = 0; m_fcyc = 0;

    // Initial reset, then check the reset state.
    set_in(1'b1, nop, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    @(posedge clk); #1;
    step(1'b0);
    set_in(1'b0, nop, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    step(1'b1);

    foreach (tbl[i]) begin
      set_in(1'b0, tbl[i].inst, tbl[i].eq, tbl[i].lt, tbl[i].hold, tbl[i].mem, tbl[i].reg_wen, tbl[i].ctrl);
      do_cycle(1'b1, 1'b1, tbl[i]);
    end

    // Reset in the middle of a flush window.
    set_in(1'b0, jal, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'h0F); step(1'b1);
    set_in(1'b0, nop, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'h0F); step(1'b1);
    chk("mid_flush_fv", 32'(flush_vec), 32'b010);
    set_in(1'b1, nop, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'h0F); step(1'b1);
    chk("rst_flush_vec", 32'(flush_vec), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_reg_wen_q", 32'(reg_wen_q), 32'd0);
    chk("rst_ctrl_q", 32'(ctrl_q), 32'd0);
    chk("rst_illegal", 32'(illegal_br_q), 32'd0);
    set_in(1'b0, nop, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 6'h07); step(1'b1);
    chk("post_rst_reg_wen_q", 32'(reg_wen_q), 32'd1);
    chk("post_rst_ctrl_q", 32'(ctrl_q), 32'h07);

    // A take seen on the reset edge is dropped.
    set_in(1'b1, jal, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0); step(1'b1);
    chk("rst_edge_take_pc_sel", 32'(pc_sel), 32'd0);
    set_in(1'b0, nop, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0); step(1'b1);

`ifdef BR_FLUSH_PERF_EN
    // Five isolated JALs: 5 takes, 5*D flush cycles.
    set_in(1'b1, nop, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0); step(1'b1);
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, jal, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0); step(1'b1);
      for (int j = 0; j < D; j++) begin
        set_in(1'b0, nop, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0); step(1'b1);
      end
    end
    chk("perf_br_taken_cnt", br_taken_cnt, 32'd5);
    chk("perf_flush_cyc_cnt", flush_cyc_cnt, 32'd15);
    chk("perf_br_cnt", br_cnt, 32'd5);
`endif

    // Random traffic against the reference model.
    pool = '{beq, bne, blt, bge, mk(OPC_BRANCH, F3_BLTU), mk(OPC_BRANCH, F3_BGEU), bill,
             mk(OPC_BRANCH, 3'b011), jal, jalr, nop, mk(OPC_LOAD, 3'd2), mk(OPC_STORE, 3'd2)};
    for (int n = 0; n < 800; n++) begin
      set_in(($urandom_range(0, 60) == 0),
             pool[$urandom_range(0, 12)] | {$urandom} & 32'hFFFF8F80,
             1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
             2'($urandom), 1'($urandom), 6'($urandom));
      step(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_flush_ctrl.md
Name: br_flush_ctrl

Overview:
- Execute-stage control-flow resolver and squash controller for the RV32I pipeline.
- Resolves branches and jumps from the instruction and the comparator flags, then redirects the PC.
- Opens a flush window of FLUSH_DEPTH cycles that kills younger instructions.
- Gates memory and register-file side effects, and registers the EX control bundle for later stages.
- Generalises the fixed 3-cycle squash to a parametrised depth and control-bundle width, and adds a redirect-source output and an illegal-branch flag.

Parameters:
- FLUSH_DEPTH, 3, number of cycles younger instructions are squashed after a redirect; legal range 1..8.
- CTRL_W, 6, width of the pass-through control bundle (load select, WB select, CSR select, ...).
- MEM_W, 2, width of the store-type/mem-write encoding; 0 means no access.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- inst  in  32  instruction currently in EX.
- br_eq  in  1  rs1==rs2 from the branch comparator.
- br_lt  in  1  rs1<rs2 from the comparator; signedness is already chosen upstream.
- hold_in  in  1  EX slot holds a bubble/stalled instruction.
- mem_we_in  in  MEM_W  decoded store type.
- reg_wen_in  in  1  decoded register write enable.
- ctrl_in  in  CTRL_W  decoded control bundle.
- mem_we_ex  out  MEM_W  combinational, gated store type.
- reg_wen_q  out  1  registered, gated write enable.
- ctrl_q  out  CTRL_W  registered control bundle.
- pc_sel  out  1  redirect the PC this cycle.
- pc_src  out  2  00 sequential, 01 branch/JAL target, 10 JALR target.
- flush_vec  out  FLUSH_DEPTH  squash shift register; bit 0 is the newest.
- flush_active  out  1  OR of flush_vec.
- illegal_br_q  out  1  registered; a branch with funct3 010/011 was seen.

Behaviour:
- Decode: opcode=inst[6:2], funct3=inst[14:12].
- Kill condition: kill = hold_in | flush_active.
- take (combinational) is 0 when kill is asserted. Otherwise:
  - Branch (11000): BEQ=br_eq, BNE=!br_eq, BLT/BLTU=br_lt, BGE/BGEU=!br_lt; funct3 010/011 gives take=0.
  - JAL (11011) and JALR (11001): take=1.
  - Any other opcode: take=0.
- Flush shift register, each posedge: flush_vec <= {flush_vec[FLUSH_DEPTH-2:0], take}. For FLUSH_DEPTH=1 it is simply flush_vec <= take.
- pc_sel = flush_vec[0]. This gives exactly one redirect pulse, one cycle after resolution.
- pc_src register:
  - On a take cycle it loads 10 for JALR, otherwise 01.
  - When take=0 it loads 00.
  - pc_src is 00 whenever pc_sel=0.
- A new take cannot occur while flush_active=1, so windows never overlap. Back-to-back branches: the second one is squashed.
- Side-effect gating:
  - mem_we_ex = kill ? 0 : mem_we_in, combinational with zero latency.
  - reg_wen_q <= kill ? 0 : reg_wen_in, one-cycle latency.
  - ctrl_q <= flush_active ? 0 : ctrl_in. hold_in does not clear ctrl_q, because a bubble's bundle is harmless once its enables are gated.
- illegal_br_q <= (opcode==branch) & (funct3 in {010,011}) & !kill. The flag is sticky until reset.
- Reset, including mid-flush: flush_vec, pc_src, reg_wen_q, ctrl_q and illegal_br_q all go to 0. pc_sel and flush_active are therefore 0 in the cycle after rst. A take sampled on the reset edge is discarded.
- Simultaneous hold_in and a taken branch: hold wins, no redirect.

Optional Feature:
- Macro: BR_FLUSH_PERF_EN.
- When defined, adds the output ports br_cnt, br_taken_cnt and flush_cyc_cnt, each CNT_W bits wide:
  - br_cnt counts unkilled branch/jump instructions.
  - br_taken_cnt counts take pulses.
  - flush_cyc_cnt counts cycles with flush_active=1.
- The counters saturate at all-ones and clear on rst.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OPC_BRANCH, OPC_JAL, OPC_JALR, ...).
  - funct3 branch constants.
  - PC_SRC_SEQ/BR/JALR encodings.
- One natural sub-module: flush_shreg, a parametrised DEPTH-bit shift register with sync clear, exposing the vector and its OR-reduction.

Test Plan:
- BEQ with br_eq=1, FLUSH_DEPTH=3 → pc_sel=1 at cycle+1 with pc_src=01; flush_vec goes 001, 010, 100, 000; mem_we_in=01 is gated to 0 for 3 cycles.
- JALR → pc_src=10 at cycle+1; a BNE taken during the window gives no second pc_sel pulse.
- BLT with br_lt=0 and reg_wen_in=1 → no redirect; reg_wen_q=1 next cycle; ctrl_q=ctrl_in.
- Taken BGE with hold_in=1 → take=0, mem_we_ex=0, reg_wen_q=0, no pc_sel.
- rst asserted while flush_vec=010 → all outputs 0 the next cycle; an instruction with reg_wen_in=1 after rst is not squashed.
- Branch with funct3=010 → no redirect, illegal_br_q=1 and it stays 1. With BR_FLUSH_PERF_EN, 5 taken JALs give br_taken_cnt=5 and flush_cyc_cnt=15.
